mem_arbiter: RTL and testbench

Shares the single 256×8 RAM port between the nic8 CPU datapath and one external DMA requester, such as a program loader or debug port. The CPU normally owns the port every cycle. The arbiter grants DMA cycles by stalling the CPU (clock-enable style) and caps DMA bursts so the CPU always makes forward progress. It sits between the CPU's abus/dbus memory port and the RAM array, and keeps a saturating stall-cycle counter for debug.

---
 rtl/nic8_pkg.sv | 15 +
 rtl/sat_counter.sv | 25 ++
 rtl/mem_arbiter.sv | 92 +++++++++
 tb/tb_mem_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/nic8_pkg.sv
// nic8_pkg: shared nic8 types and default widths
//   owner_t      : which requester currently owns the RAM port
//   NIC8_ADDR_W  : default address width (RAM depth 2^NIC8_ADDR_W)
//   NIC8_DATA_W  : default data width
package nic8_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam int NIC8_ADDR_W = 8;
    localparam int NIC8_DATA_W = 8;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at its all-ones value
//   clk, reset : clock and synchronous active-high clear
//   inc        : count one at this posedge
//   count      : current value, saturates at 2^WIDTH-1
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset)
            count_q <= '0;
        else if (inc && count_q != '1)
            count_q <= count_q + 1'b1;
    end

    assign count = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the nic8 CPU and a DMA requester
//   cpu_*        : CPU memory port; cpu_stall freezes the CPU for the cycle
//   dma_*        : DMA request/grant port with registered read data
//   mem_*        : single RAM port (combinational read, write at posedge)
//   stall_cycles : saturating count of cycles the CPU was stalled
module mem_arbiter
    import nic8_pkg::*;
#(
    parameter int ADDR_W    = NIC8_ADDR_W,
    parameter int DATA_W    = NIC8_DATA_W,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    input  logic              cpu_halt,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_we,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);

    owner_t              owner_q;
    logic [BURST_W-1:0]  burst_q;
    logic [DATA_W-1:0]   dma_rdata_q;
    logic                dma_rvalid_q;
    logic                dma_sel;
    logic                last_beat;
    logic                burst_full;

    // DMA drives the port only while it owns it and is still requesting;
    // a dropped request hands the cycle straight back to the CPU.
    assign dma_sel    = owner_q == OWN_DMA && dma_req && !reset;
    // Under halt the burst keeps counting but is held at MAX_BURST so the
    // cap takes effect on the first grant after halt is released.
    assign last_beat  = int'(burst_q) + 1 >= MAX_BURST;
    assign burst_full = int'(burst_q) >= MAX_BURST;

    assign mem_addr     = dma_sel ? dma_addr : cpu_addr;
    assign mem_wdata    = dma_sel ? dma_wdata : cpu_wdata;
    assign mem_we       = reset ? 1'b0 : dma_sel ? dma_we : cpu_we && !cpu_halt;
    assign cpu_stall    = reset || dma_sel || cpu_halt;
    assign dma_gnt      = dma_sel;
    assign cpu_rdata    = mem_rdata;
    assign dma_rdata    = dma_rdata_q;
    assign dma_rvalid   = dma_rvalid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q      <= OWN_CPU;
            burst_q      <= '0;
            dma_rvalid_q <= 1'b0;
            dma_rdata_q  <= '0;
        end else begin
            if (dma_sel) begin
                burst_q <= burst_full ? burst_q : burst_q + 1'b1;
                owner_q <= (last_beat && !cpu_halt) ? OWN_CPU : OWN_DMA;
            end else begin
                burst_q <= '0;
                owner_q <= dma_req ? OWN_DMA : OWN_CPU;
            end
            dma_rvalid_q <= dma_sel && !dma_we;
            if (dma_sel && !dma_we)
                dma_rdata_q <= mem_rdata;
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (cpu_stall && !reset),
        .count(stall_cycles)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       cpu_we, cpu_halt, cpu_stall;
    logic       dma_req, dma_we, dma_gnt, dma_rvalid;
    logic [7:0] dma_addr, dma_wdata, dma_rdata;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we;
    logic [3:0] stall_cycles;

    logic [7:0] ram [256] = '{default: 8'h00};

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_we) ram[mem_addr] <= mem_wdata;

    assign mem_rdata = ram[mem_addr];

    mem_arbiter #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .MAX_BURST(4),
        .CNT_W    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_we      (cpu_we),
        .cpu_halt    (cpu_halt),
        .cpu_rdata   (cpu_rdata),
        .cpu_stall   (cpu_stall),
        .dma_req     (dma_req),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_we      (dma_we),
        .dma_gnt     (dma_gnt),
        .dma_rdata   (dma_rdata),
        .dma_rvalid  (dma_rvalid),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata),
        .stall_cycles(stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    logic [10:0] burst_pat;

    initial begin
        reset = 1'b1; cpu_addr = 8'h00; cpu_wdata = 8'h00; cpu_we = 1'b1; cpu_halt = 1'b0;
        dma_req = 1'b1; dma_addr = 8'h00; dma_wdata = 8'h00; dma_we = 1'b1;
        burst_pat = 11'b01111011110;

        // reset gating
        settle();
        chk("rst_gnt", dma_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_stall", cpu_stall, 1);
        tick(); tick();

        // idle CPU store
        reset = 1'b0; dma_req = 1'b0; cpu_addr = 8'h10; cpu_wdata = 8'h5A; cpu_we = 1'b1;
        settle();
        chk("idle_stall", cpu_stall, 0);
        chk("idle_mem_we", mem_we, 1);
        chk("rst_rvalid", dma_rvalid, 0);
        chk("rst_rdata", dma_rdata, 0);
        chk("rst_cnt", stall_cycles, 0);
        tick();
        chk("idle_ram10", ram[8'h10], 8'h5A);
        chk("idle_cnt", stall_cycles, 0);

        // single DMA write
        cpu_we = 1'b0; dma_req = 1'b1; dma_addr = 8'h80; dma_wdata = 8'hC3; dma_we = 1'b1;
        settle();
        chk("single_k_gnt", dma_gnt, 0);
        chk("single_k_stall", cpu_stall, 0);
        tick();
        settle();
        chk("single_k1_gnt", dma_gnt, 1);
        chk("single_k1_stall", cpu_stall, 1);
        chk("single_k1_addr", mem_addr, 8'h80);
        tick();
        chk("single_ram80", ram[8'h80], 8'hC3);
        chk("single_rvalid", dma_rvalid, 0);
        dma_req = 1'b0;
        settle();
        chk("single_k2_gnt", dma_gnt, 0);
        chk("single_k2_stall", cpu_stall, 0);
        chk("single_cnt", stall_cycles, 1);
        tick();

        // burst cap: grants 1111 0 1111 0 after the request cycle
        dma_req = 1'b1; dma_addr = 8'h90; dma_wdata = 8'h11; dma_we = 1'b1; cpu_we = 1'b1;
        for (int c = 0; c < 11; c++) begin
            cpu_addr = 8'h40 + 8'(c);
            cpu_wdata = 8'h60 + 8'(c);
            settle();
            chk($sformatf("burst_gnt_%0d", c), dma_gnt, burst_pat[c]);
            chk($sformatf("burst_stall_%0d", c), cpu_stall, burst_pat[c]);
            tick();
            chk($sformatf("burst_cpu_ram_%0d", c), ram[8'h40 + 8'(c)],
                burst_pat[c] ? 8'h00 : 8'h60 + 8'(c));
        end
        dma_req = 1'b0; cpu_we = 1'b0;
        settle();
        chk("burst_release_gnt", dma_gnt, 0);
        tick();
        chk("burst_ram90", ram[8'h90], 8'h11);
        chk("burst_cnt", stall_cycles, 9);

        // halt streaming: preload 0x00..0x07, then 8 back-to-back DMA reads
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("halt_cnt_clr", stall_cycles, 0);
        cpu_we = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cpu_addr = 8'(i);
            cpu_wdata = 8'hA0 + 8'(i);
            tick();
        end
        cpu_halt = 1'b1; cpu_addr = 8'hF0; cpu_wdata = 8'hEE;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h00;
        settle();
        chk("halt_h0_gnt", dma_gnt, 0);
        chk("halt_h0_stall", cpu_stall, 1);
        chk("halt_h0_mem_we", mem_we, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            dma_addr = 8'(i);
            settle();
            chk($sformatf("halt_gnt_%0d", i), dma_gnt, 1);
            tick();
            chk($sformatf("halt_rvalid_%0d", i), dma_rvalid, 1);
            chk($sformatf("halt_rdata_%0d", i), dma_rdata, 8'hA0 + 8'(i));
        end
        dma_req = 1'b0;
        settle();
        chk("halt_h9_gnt", dma_gnt, 0);
        tick();
        chk("halt_rvalid_drop", dma_rvalid, 0);
        chk("halt_rdata_hold", dma_rdata, 8'hA7);
        chk("halt_no_cpu_wr", ram[8'hF0], 8'h00);
        chk("halt_cnt", stall_cycles, 10);

        // conflict: DMA write wins over CPU store, then reset on the 2nd grant
        cpu_halt = 1'b0; cpu_we = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h20; dma_wdata = 8'hD1;
        tick();
        cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'h77;
        settle();
        chk("conf_gnt", dma_gnt, 1);
        chk("conf_stall", cpu_stall, 1);
        chk("conf_wdata", mem_wdata, 8'hD1);
        tick();
        chk("conf_ram20", ram[8'h20], 8'hD1);
        reset = 1'b1; cpu_we = 1'b0; dma_addr = 8'h21; dma_wdata = 8'hB2;
        settle();
        chk("midrst_gnt", dma_gnt, 0);
        chk("midrst_mem_we", mem_we, 0);
        chk("midrst_stall", cpu_stall, 1);
        tick();
        chk("midrst_ram21", ram[8'h21], 8'h00);
        reset = 1'b0;
        settle();
        chk("midrst_owner_cpu", dma_gnt, 0);
        tick();
        settle();
        chk("midrst_regrant", dma_gnt, 1);
        tick();
        chk("midrst_ram21_late", ram[8'h21], 8'hB2);
        dma_req = 1'b0;

        // stall counter saturation
        reset = 1'b1;
        tick();
        reset = 1'b0; cpu_halt = 1'b1; dma_req = 1'b1; dma_we = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) chk("sat_14", stall_cycles, 14);
            if (i == 15) chk("sat_15", stall_cycles, 15);
        end
        chk("sat_20", stall_cycles, 15);
        cpu_halt = 1'b0; dma_req = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
